// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - drives a PUF subblock through a challenge sequence and assembles the response
//
// Purpose:
//   Runs NUM_BITS races on one puf_parallel_subblock, one challenge per bit. Each bit
//   walks CLEAR -> ARM -> RACE -> CAPTURE -> NEXT. After the last bit the block
//   pulses resp_valid in DONE. A race that never finishes is abandoned after
//   TIMEOUT_CYCLES and scores 0.
//
// Optional build macro:
//   PUF_MAJORITY_VOTE_EN - each challenge is raced three times. The response bit is
//   the majority of the three outcomes. A timed-out race counts as 0.
//
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   start, seed_challenge  run request (honoured only in IDLE) and first challenge
//   busy                   high from the cycle after start is accepted until DONE exits
//   resp_valid             one-cycle pulse, high while in DONE
//   response               bit i is the outcome of challenge i
//   timeout_err            sticky per run; set if any race timed out
//   puf_challenge          challenge to the subblock
//   puf_enable             ring oscillator enables to the subblock
//   puf_reset              active-high reset to the subblock counters and arbiter
//   puf_out, puf_done      subblock result and done, asynchronous to clock
module puf_challenge_sequencer #(
  parameter int NUM_BITS       = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          seed_challenge,
  output logic                busy,
  output logic                resp_valid,
  output logic [NUM_BITS-1:0] response,
  output logic                timeout_err,
  output logic [7:0]          puf_challenge,
  output logic [31:0]         puf_enable,
  output logic                puf_reset,
  input  logic                puf_out,
  input  logic                puf_done
);

  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_RACE,
    S_CAPTURE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] bit_idx;
  logic [SET_W-1:0] settle_cnt;
  logic [15:0]      to_cnt;
  logic             race_timed_out;
  logic             done_meta;
  logic             done_s;
  logic             out_meta;
  logic             out_s;
  logic             cap_bit;
  logic             last_race;

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] vote_cnt;
  logic [1:0] ones_cnt;
  assign last_race = (vote_cnt == 2'd2);
`else
  assign last_race = 1'b1;
`endif

  // A timed-out race scores 0 regardless of what the arbiter output shows.
  assign cap_bit = race_timed_out ? 1'b0 : out_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    puf_reset  = 1'b1;
    puf_enable = 32'h0000_0000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (settle_cnt == SET_LAST) state_nxt = S_ARM;
      end
      S_ARM: begin
        puf_reset  = 1'b0;
        puf_enable = 32'hFFFF_FFFF;
        state_nxt  = S_RACE;
      end
      S_RACE: begin
        puf_reset  = 1'b0;
        puf_enable = 32'hFFFF_FFFF;
        if (done_s || (to_cnt == TO_LAST)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Oscillators stop here; the counters keep their values for this cycle.
        puf_reset = 1'b0;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (last_race && (bit_idx == IDX_LAST)) state_nxt = S_DONE;
        else state_nxt = S_CLEAR;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy           <= 1'b0;
      resp_valid     <= 1'b0;
      response       <= '0;
      timeout_err    <= 1'b0;
      puf_challenge  <= 8'h00;
      bit_idx        <= '0;
      settle_cnt     <= '0;
      to_cnt         <= 16'h0000;
      race_timed_out <= 1'b0;
      done_meta      <= 1'b0;
      done_s         <= 1'b0;
      out_meta       <= 1'b0;
      out_s          <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_cnt       <= 2'd0;
      ones_cnt       <= 2'd0;
`endif
    end else begin
      done_meta  <= puf_done;
      done_s     <= done_meta;
      out_meta   <= puf_out;
      out_s      <= out_meta;
      resp_valid <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            bit_idx       <= '0;
            puf_challenge <= seed_challenge;
            response      <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            settle_cnt    <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_cnt      <= 2'd0;
            ones_cnt      <= 2'd0;
`endif
          end
        end
        S_CLEAR: begin
          if (settle_cnt == SET_LAST) settle_cnt <= '0;
          else settle_cnt <= settle_cnt + SET_W'(1);
        end
        S_ARM: begin
          to_cnt         <= 16'h0000;
          race_timed_out <= 1'b0;
        end
        S_RACE: begin
          if (!done_s) begin
            if (to_cnt == TO_LAST) begin
              timeout_err    <= 1'b1;
              race_timed_out <= 1'b1;
            end else if (to_cnt != 16'hFFFF) begin
              to_cnt <= to_cnt + 16'd1;
            end
          end
        end
        S_CAPTURE: begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (last_race) begin
            // Majority of three: the earlier two outcomes are summarised in ones_cnt.
            response[bit_idx] <= (ones_cnt == 2'd2) || ((ones_cnt == 2'd1) && cap_bit);
          end else if (cap_bit) begin
            ones_cnt <= ones_cnt + 2'd1;
          end
`else
          response[bit_idx] <= cap_bit;
`endif
        end
        S_NEXT: begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (!last_race) begin
            vote_cnt <= vote_cnt + 2'd1;
          end else begin
            vote_cnt <= 2'd0;
            ones_cnt <= 2'd0;
          end
`endif
          if (last_race && (bit_idx != IDX_LAST)) begin
            bit_idx       <= bit_idx + IDX_W'(1);
            puf_challenge <= puf_challenge + 8'd1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - table-driven bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

  localparam int NB   = 4;
  localparam int SET  = 4;
  localparam int TO   = 100;
  localparam int DLY  = 20;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VOTES = 3;
`else
  localparam int VOTES = 1;
`endif
  localparam int RACES = NB * VOTES;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    seed_challenge = 8'h00;
  logic          busy;
  logic          resp_valid;
  logic [NB-1:0] response;
  logic          timeout_err;
  logic [7:0]    puf_challenge;
  logic [31:0]   puf_enable;
  logic          puf_reset;
  logic          puf_out = 1'b0;
  logic          puf_done = 1'b0;

  puf_challenge_sequencer #(
    .NUM_BITS(NB),
    .SETTLE_CYCLES(SET),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .seed_challenge(seed_challenge),
    .busy(busy),
    .resp_valid(resp_valid),
    .response(response),
    .timeout_err(timeout_err),
    .puf_challenge(puf_challenge),
    .puf_enable(puf_enable),
    .puf_reset(puf_reset),
    .puf_out(puf_out),
    .puf_done(puf_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  seed;
    logic [11:0] pat;
    logic [11:0] hang;
    logic [3:0]  exp_resp;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[4];
  int   nvec;
  int   total = 0;
  int   bad = 0;

  // Subblock model state, written only by the model process.
  int          arm_total = 0;
  int          rv_total = 0;
  int          cnt = 0;
  int          ri = 0;
  logic        prev_en = 1'b0;
  logic [7:0]  chal_log[256];
  int          en_len[256];

  // Per-run stimulus, written only by the main initial block.
  int          arm_base = 0;
  logic [11:0] cur_pat = 12'h000;
  logic [11:0] cur_hang = 12'h000;

  always @(negedge clock) begin
    if (resp_valid) rv_total = rv_total + 1;
    if (puf_enable == 32'hFFFF_FFFF && !prev_en) begin
      chal_log[arm_total % 256] = puf_challenge;
      ri = arm_total - arm_base;
      arm_total = arm_total + 1;
      cnt = 0;
    end
    if (puf_enable == 32'hFFFF_FFFF) cnt = cnt + 1;
    if (prev_en && puf_enable != 32'hFFFF_FFFF) en_len[(arm_total - 1) % 256] = cnt;
    prev_en = (puf_enable == 32'hFFFF_FFFF);
    if (puf_reset) begin
      puf_done = 1'b0;
      puf_out  = 1'b0;
    end else if (puf_enable == 32'hFFFF_FFFF && cnt >= DLY && ri >= 0 && ri < 12) begin
      if (!cur_hang[ri]) begin
        puf_done = 1'b1;
        puf_out  = cur_pat[ri];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] seed);
    seed_challenge = seed;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for resp_valid while counting cycles in which busy dropped early.
  task automatic wait_resp(output logic got, output int lows);
    got = 1'b0;
    lows = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      if (resp_valid) got = 1'b1;
      else begin
        if (!busy) lows = lows + 1;
        tick();
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic       got;
    int         lows;
    int         rv0;
    logic [7:0] ec;
    arm_base = arm_total;
    cur_pat  = v.pat;
    cur_hang = v.hang;
    rv0      = rv_total;
    tick();
    pulse_start(v.seed);
    check($sformatf("v%0d busy_after_start", id), busy, 1);
    wait_resp(got, lows);
    check($sformatf("v%0d resp_valid_seen", id), got, 1);
    check($sformatf("v%0d busy_low_during_run", id), lows, 0);
    check($sformatf("v%0d response", id), response, v.exp_resp);
    check($sformatf("v%0d timeout_err", id), timeout_err, v.exp_terr);
    tick();
    check($sformatf("v%0d busy_after_done", id), busy, 0);
    check($sformatf("v%0d resp_valid_pulses", id), rv_total - rv0, 1);
    check($sformatf("v%0d arm_count", id), arm_total - arm_base, RACES);
    for (int r = 0; r < RACES; r++) begin
      ec = v.seed + 8'(r / VOTES);
      check($sformatf("v%0d challenge_race%0d", id, r), chal_log[(arm_base + r) % 256], ec);
      if (v.hang[r]) check($sformatf("v%0d timeout_len_race%0d", id, r), en_len[(arm_base + r) % 256], TO + 1);
    end
  endtask

  initial begin
    logic got;
    int   lows;
    int   rv0;
    int   waited;

`ifdef PUF_MAJORITY_VOTE_EN
    nvec = 2;
    vecs[0] = '{seed: 8'h10, pat: 12'h0E5, hang: 12'h000, exp_resp: 4'b0101, exp_terr: 1'b0};
    vecs[1] = '{seed: 8'hFE, pat: 12'hFFF, hang: 12'h003, exp_resp: 4'b1110, exp_terr: 1'b1};
    vecs[2] = vecs[0];
    vecs[3] = vecs[0];
`else
    nvec = 4;
    vecs[0] = '{seed: 8'h10, pat: 12'h00D, hang: 12'h000, exp_resp: 4'b1101, exp_terr: 1'b0};
    vecs[1] = '{seed: 8'hFE, pat: 12'h006, hang: 12'h000, exp_resp: 4'b0110, exp_terr: 1'b0};
    vecs[2] = '{seed: 8'h20, pat: 12'h00F, hang: 12'h004, exp_resp: 4'b1011, exp_terr: 1'b1};
    vecs[3] = '{seed: 8'hFF, pat: 12'h009, hang: 12'h000, exp_resp: 4'b1001, exp_terr: 1'b0};
`endif

    // Reset state
    #22;
    check("rst busy", busy, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst response", response, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst puf_challenge", puf_challenge, 0);
    check("rst puf_enable", puf_enable, 0);
    check("rst puf_reset", puf_reset, 1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // start pulsed mid-run and during DONE must both be ignored
    arm_base = arm_total;
    cur_pat  = vecs[0].pat;
    cur_hang = vecs[0].hang;
    rv0 = rv_total;
    pulse_start(vecs[0].seed);
    repeat (30) tick();
    pulse_start(8'h55);
    wait_resp(got, lows);
    check("ign resp_valid_seen", got, 1);
    seed_challenge = 8'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("ign resp_valid_pulses", rv_total - rv0, 1);
    check("ign busy_idle", busy, 0);
    check("ign response", response, vecs[0].exp_resp);
    check("ign arm_count", arm_total - arm_base, RACES);
    check("ign last_challenge", chal_log[(arm_base + RACES - 1) % 256], vecs[0].seed + 8'(NB - 1));

    // Asynchronous reset during the race of bit 1 aborts the run
    arm_base = arm_total;
    rv0 = rv_total;
    pulse_start(vecs[0].seed);
    waited = 0;
    while ((arm_total - arm_base) < VOTES + 1 && waited < 2000) begin
      tick();
      waited++;
    end
    check("abort reached_bit1", waited < 2000, 1);
    repeat (5) tick();
    check("abort in_race", puf_enable, 32'hFFFF_FFFF);
    reset = 1'b0;
    #1;
    check("abort puf_reset", puf_reset, 1);
    check("abort puf_enable", puf_enable, 0);
    check("abort busy", busy, 0);
    check("abort response", response, 0);
    check("abort puf_challenge", puf_challenge, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("abort no_resp_valid", rv_total - rv0, 0);
    run_vec(vecs[0], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
